// File: rtl/fwd_hazard_ctrl.sv
// Decode-stage forwarding select and load-use stall controller with an internal tracker of in-flight writes.
// Selects and stall are combinational from ID inputs and tracker state; tracker and stall counter update on clk.
module fwd_hazard_ctrl #(
   parameter int REG_AW     = 5,
   parameter int NUM_SRC    = 2,
   parameter int DEPTH      = 3,
   parameter int ALU_READY  = 1,
   parameter int LOAD_READY = 2,
   parameter int SELW       = $clog2(DEPTH+1),
   parameter int CNT_W      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      id_valid,
   input  logic                      id_regwrite,
   input  logic                      id_is_load,
   input  logic [REG_AW-1:0]         id_rd,
   input  logic [NUM_SRC*REG_AW-1:0] id_rs,
   input  logic [NUM_SRC-1:0]        id_rs_used,
   input  logic                      stall_ext,
   input  logic                      flush,
   output logic [NUM_SRC*SELW-1:0]   fwd_sel,
   output logic                      hazard_stall,
   output logic [CNT_W-1:0]          stall_cnt
);

   logic [DEPTH-1:0]  v_q;
   logic [DEPTH-1:0]  ld_q;
   logic [REG_AW-1:0] rd_q [DEPTH];
   logic [NUM_SRC-1:0] not_ready;
   logic [REG_AW-1:0]  rs_cur;

   // Walk oldest to youngest so the youngest matching producer overrides older ones.
   always_comb begin
      fwd_sel   = '0;
      not_ready = '0;
      rs_cur    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         rs_cur = id_rs[i*REG_AW +: REG_AW];
         if (id_valid && id_rs_used[i] && rs_cur != '0) begin
            for (int k = DEPTH-1; k >= 0; k--) begin
               if (v_q[k] && rd_q[k] == rs_cur) begin
                  if (k >= (ld_q[k] ? LOAD_READY : ALU_READY)) begin
                     fwd_sel[i*SELW +: SELW] = SELW'(k+1);
                     not_ready[i]            = 1'b0;
                  end else begin
                     fwd_sel[i*SELW +: SELW] = '0;
                     not_ready[i]            = 1'b1;
                  end
               end
            end
         end
      end
   end

   assign hazard_stall = (|not_ready) & ~flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q       <= '0;
         stall_cnt <= '0;
      end else if (stall_ext) begin
         if (flush)
            v_q[0] <= 1'b0;
      end else begin
         for (int k = DEPTH-1; k >= 1; k--) begin
            v_q[k]  <= v_q[k-1];
            ld_q[k] <= ld_q[k-1];
            rd_q[k] <= rd_q[k-1];
         end
         // A stalled or killed ID instruction leaves a bubble behind it.
         v_q[0]  <= id_valid & id_regwrite & (id_rd != '0) & ~hazard_stall & ~flush;
         ld_q[0] <= id_is_load;
         rd_q[0] <= id_rd;
         if (hazard_stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
